// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction width, default address width / reset PC,
// and the fetch FSM state encoding.
package cpu_pkg;

   localparam int INSTR_W      = 16;
   localparam int ADDR_W_DEF   = 8;
   localparam int RESET_PC_DEF = 0;
   localparam int LAT_CNT_W    = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_EXEC  = 2'd3;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter register: load beats increment beats hold; wraps modulo 2^ADDR_W.
module pc_counter
   import cpu_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int RESET_PC = RESET_PC_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                inc,
   input  logic [ADDR_W-1:0]   load_val,
   output logic [ADDR_W-1:0]   pc,
   output logic [INSTR_W-1:0]  pc_out
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= ADDR_W'(RESET_PC);
      end else if (load) begin
         pc <= load_val;
      end else if (inc) begin
         pc <= pc + ADDR_W'(1);
      end
   end

   assign pc_out = INSTR_W'(pc);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and instruction register, shares the RAM
// address port with control-unit data accesses.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int RAM_LAT  = 1,
   parameter int RESET_PC = RESET_PC_DEF
) (
   input  logic                clk,
   input  logic                rst,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic                ram_rd,
   input  logic [INSTR_W-1:0]  ram_rdata,
   input  logic                data_sel,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [INSTR_W-1:0]  bus_in,
   input  logic                pc_load,
   output logic [INSTR_W-1:0]  pc_out,
   output logic [INSTR_W-1:0]  instr,
   output logic                instr_valid,
   input  logic                instr_done
);

   logic [1:0]           state;
   logic [LAT_CNT_W-1:0] wait_cnt;
   logic [ADDR_W-1:0]    pc;
   logic                 pc_load_en;
   logic                 pc_inc;
   logic                 capture;
   logic                 unused_bus;

   assign unused_bus = ^bus_in;

   assign capture    = (state == ST_WAIT) && (wait_cnt == '0);
   assign pc_load_en = (state == ST_EXEC) && pc_load;
   assign pc_inc     = capture;

   assign ram_addr = data_sel ? data_addr : pc;
   // The RAM latches its address on ram_rd, so only FETCH needs the port free.
   assign ram_rd   = rst && (state == ST_FETCH) && !data_sel;

   pc_counter #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk      (clk),
      .rst      (rst),
      .load     (pc_load_en),
      .inc      (pc_inc),
      .load_val (bus_in[ADDR_W-1:0]),
      .pc       (pc),
      .pc_out   (pc_out)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         wait_cnt    <= '0;
         instr       <= '0;
         instr_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: state <= ST_FETCH;
            ST_FETCH: begin
               if (!data_sel) begin
                  wait_cnt <= LAT_CNT_W'(RAM_LAT - 1);
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (wait_cnt != '0) begin
                  wait_cnt <= wait_cnt - LAT_CNT_W'(1);
               end else begin
                  instr       <= ram_rdata;
                  instr_valid <= 1'b1;
                  state       <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (instr_done) begin
                  instr_valid <= 1'b0;
                  state       <= ST_FETCH;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
